pcs_rx_lock_ctrl: RTL and testbench

- Receive-side block-lock controller for the 40GbE PCS; consumes the 4 sync headers per cycle that accompany each 256-bit (4 x 64b) payload word from the RX gearbox.
- Runs the sync-header lock state machine and pulses `slip` to the gearbox until alignment is found.
- Drives the descrambler `bypass` (bypass while unlocked) and flags when descrambled data is trustworthy after the self-synchronising scrambler has flushed.

---
 rtl/pcs_rx_lock_ctrl_pkg.sv | 20 ++
 rtl/pcs_rx_lock_ctrl_if.sv | 25 ++
 rtl/pcs_rx_lock_ctrl_sh_check.sv | 21 ++
 rtl/pcs_rx_lock_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pcs_rx_lock_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/pcs_rx_lock_ctrl_pkg.sv
// Shared types and helpers for the 40GbE PCS receive block-lock controller.
// Contents: lock_state_t FSM encoding, the two valid sync-header encodings
// and sh_invalid(), which flags a 2-bit sync header as 00 or 11.
package pcs_rx_lock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED  = 2'd0,
        ST_SLIP_WAIT = 2'd1,
        ST_LOCKED    = 2'd2
    } lock_state_t;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // A header is valid only as a data (01) or control (10) marker.
    function automatic logic sh_invalid(input logic [1:0] hdr);
        return !((hdr == SH_DATA) || (hdr == SH_CTRL));
    endfunction

endpackage

// File: rtl/pcs_rx_lock_ctrl_if.sv
// Gearbox-to-lock-controller bundle.
// master: gearbox side, drives hdr_valid/sync_hdr and observes lock status.
// slave : lock controller, consumes headers and drives slip/block_lock/
//         descr_bypass/data_ok/hi_ber.
interface pcs_rx_lock_ctrl_if #(
    parameter int unsigned LANES = 4
);
    logic                   hdr_valid;
    logic [2*LANES-1:0]     sync_hdr;
    logic                   slip;
    logic                   block_lock;
    logic                   descr_bypass;
    logic                   data_ok;
    logic                   hi_ber;

    modport master (
        output hdr_valid, sync_hdr,
        input  slip, block_lock, descr_bypass, data_ok, hi_ber
    );

    modport slave (
        input  hdr_valid, sync_hdr,
        output slip, block_lock, descr_bypass, data_ok, hi_ber
    );
endinterface

// File: rtl/pcs_rx_lock_ctrl_sh_check.sv
// Combinational sync-header checker: counts lanes whose header is 00 or 11.
// Ports: sync_hdr (lane i at [2i+1:2i]) in, n_inv_c (0..LANES) out.
// Kept standalone so the TX loopback checker can reuse it.
module pcs_rx_lock_ctrl_sh_check
    import pcs_rx_lock_ctrl_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic [2*LANES-1:0]          sync_hdr,
    output logic [$clog2(LANES+1)-1:0]  n_inv_c
);
    localparam int unsigned NI_W = $clog2(LANES + 1);

    // Population count of invalid lane headers.
    always_comb begin
        n_inv_c = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            n_inv_c = n_inv_c + NI_W'(sh_invalid(sync_hdr[2*i +: 2]));
        end
    end
endmodule

// File: rtl/pcs_rx_lock_ctrl.sv
// 40GbE PCS receive block-lock controller.
// Runs the sync-header lock FSM over LANES headers per cycle, pulses slip to
// the gearbox while searching, releases descrambler bypass once locked and
// raises data_ok after the self-synchronising scrambler has flushed.
// Ports: clk; reset (synchronous, active-low); bus (pcs_rx_lock_ctrl_if.slave):
//   hdr_valid/sync_hdr in; slip (same-cycle pulse), block_lock, descr_bypass,
//   data_ok, hi_ber out.
// Optional: define PCS_HI_BER_EN to build the hi-BER monitor; otherwise
//   hi_ber is tied low.
module pcs_rx_lock_ctrl
    import pcs_rx_lock_ctrl_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned LOCK_CNT  = 64,
    parameter int unsigned WINDOW    = 1024,
    parameter int unsigned INV_LIMIT = 65,
    parameter int unsigned SLIP_WAIT = 8,
    parameter int unsigned FLUSH_CYC = 1,
    parameter int unsigned BER_CYC   = 19531,
    parameter int unsigned BER_LIMIT = 97
) (
    input  logic            clk,
    input  logic            reset,
    pcs_rx_lock_ctrl_if.slave bus
);
    localparam int unsigned NI_W = $clog2(LANES + 1);
    localparam int unsigned SH_W = $clog2(WINDOW + 1);
    localparam int unsigned IV_W = $clog2(INV_LIMIT + LANES);
    localparam int unsigned SW_W = $clog2(SLIP_WAIT + 1);
    localparam int unsigned FL_W = $clog2(FLUSH_CYC + 1);

    // Elaboration-time parameter sanity.
    if ((LOCK_CNT % LANES) != 0 || (WINDOW % LANES) != 0) begin : g_bad_mult
        $error("LOCK_CNT and WINDOW must be multiples of LANES");
    end
    if (SLIP_WAIT == 0 || FLUSH_CYC == 0) begin : g_bad_wait
        $error("SLIP_WAIT and FLUSH_CYC must be at least 1");
    end
    if (BER_CYC < 2 || BER_LIMIT == 0) begin : g_bad_ber
        $error("BER_CYC must be >= 2 and BER_LIMIT >= 1");
    end

    lock_state_t        state, state_n;
    logic [SH_W-1:0]    sh_cnt, sh_cnt_n;
    logic [IV_W-1:0]    inv_cnt, inv_cnt_n, inv_next;
    logic [SW_W-1:0]    wait_cnt, wait_cnt_n;
    logic [FL_W-1:0]    fl_cnt, fl_cnt_n;
    logic [NI_W-1:0]    n_inv;
    logic               slip_c;
    logic               block_lock_q, descr_bypass_q, data_ok_q, data_ok_n;
    logic               hi_ber_n;

    pcs_rx_lock_ctrl_sh_check #(.LANES(LANES)) u_sh_check (
        .sync_hdr (bus.sync_hdr),
        .n_inv_c  (n_inv)
    );

    // Lock FSM: next state, counter updates and the Mealy slip request.
    always_comb begin
        state_n    = state;
        sh_cnt_n   = sh_cnt;
        inv_cnt_n  = inv_cnt;
        wait_cnt_n = '0;
        slip_c     = 1'b0;
        inv_next   = inv_cnt + IV_W'(n_inv);
        case (state)
            ST_UNLOCKED: begin
                if (bus.hdr_valid) begin
                    if (n_inv != '0) begin
                        slip_c    = 1'b1;
                        state_n   = ST_SLIP_WAIT;
                        sh_cnt_n  = '0;
                        inv_cnt_n = '0;
                    end else if (sh_cnt + SH_W'(LANES) == SH_W'(LOCK_CNT)) begin
                        state_n   = ST_LOCKED;
                        sh_cnt_n  = '0;
                        inv_cnt_n = '0;
                    end else begin
                        sh_cnt_n  = sh_cnt + SH_W'(LANES);
                    end
                end
            end
            ST_SLIP_WAIT: begin
                // Gearbox realign time; runs whether or not headers are valid.
                if (wait_cnt == SW_W'(SLIP_WAIT - 1)) begin
                    state_n   = ST_UNLOCKED;
                    sh_cnt_n  = '0;
                    inv_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + SW_W'(1);
                end
            end
            ST_LOCKED: begin
                if (bus.hdr_valid) begin
                    // Loss of lock outranks the window boundary in the same cycle.
                    if (inv_next >= IV_W'(INV_LIMIT)) begin
                        slip_c    = 1'b1;
                        state_n   = ST_SLIP_WAIT;
                        sh_cnt_n  = '0;
                        inv_cnt_n = '0;
                    end else if (sh_cnt + SH_W'(LANES) == SH_W'(WINDOW)) begin
                        sh_cnt_n  = '0;
                        inv_cnt_n = '0;
                    end else begin
                        sh_cnt_n  = sh_cnt + SH_W'(LANES);
                        inv_cnt_n = inv_next;
                    end
                end
            end
            default: begin
                state_n   = ST_UNLOCKED;
                sh_cnt_n  = '0;
                inv_cnt_n = '0;
            end
        endcase
    end

    // Scrambler flush: count locked cycles since bypass fell, restart on relock.
    always_comb begin
        fl_cnt_n = '0;
        if (block_lock_q && state_n == ST_LOCKED) begin
            fl_cnt_n = (fl_cnt == FL_W'(FLUSH_CYC)) ? fl_cnt : fl_cnt + FL_W'(1);
        end
        data_ok_n = (state_n == ST_LOCKED) && (fl_cnt_n == FL_W'(FLUSH_CYC)) && !hi_ber_n;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_UNLOCKED;
            sh_cnt         <= '0;
            inv_cnt        <= '0;
            wait_cnt       <= '0;
            fl_cnt         <= '0;
            block_lock_q   <= 1'b0;
            descr_bypass_q <= 1'b1;
            data_ok_q      <= 1'b0;
        end else begin
            state          <= state_n;
            sh_cnt         <= sh_cnt_n;
            inv_cnt        <= inv_cnt_n;
            wait_cnt       <= wait_cnt_n;
            fl_cnt         <= fl_cnt_n;
            block_lock_q   <= (state_n == ST_LOCKED);
            descr_bypass_q <= (state_n != ST_LOCKED);
            data_ok_q      <= data_ok_n;
        end
    end

`ifdef PCS_HI_BER_EN
    localparam int unsigned BC_W = $clog2(BER_CYC);
    localparam int unsigned BL_W = $clog2(BER_LIMIT + 1);
    localparam int unsigned BS_W = BL_W + 1;

    logic [BC_W-1:0] ber_cyc_q, ber_cyc_n;
    logic [BL_W-1:0] ber_cnt_q, ber_cnt_n, ber_sat;
    logic [BS_W-1:0] ber_sum;
    logic            hi_ber_q;

    // BER window: accumulate invalid headers while locked; unlock clears the
    // window but leaves hi_ber as it was.
    always_comb begin
        ber_cyc_n = '0;
        ber_cnt_n = '0;
        ber_sum   = '0;
        ber_sat   = '0;
        hi_ber_n  = hi_ber_q;
        if (block_lock_q) begin
            ber_sum = BS_W'(ber_cnt_q) + (bus.hdr_valid ? BS_W'(n_inv) : BS_W'(0));
            ber_sat = (ber_sum >= BS_W'(BER_LIMIT)) ? BL_W'(BER_LIMIT) : ber_sum[BL_W-1:0];
            if (ber_sat == BL_W'(BER_LIMIT)) begin
                hi_ber_n = 1'b1;
            end
            if (ber_cyc_q == BC_W'(BER_CYC - 1)) begin
                if (ber_sat < BL_W'(BER_LIMIT)) begin
                    hi_ber_n = 1'b0;
                end
            end else begin
                ber_cyc_n = ber_cyc_q + BC_W'(1);
                ber_cnt_n = ber_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ber_cyc_q <= '0;
            ber_cnt_q <= '0;
            hi_ber_q  <= 1'b0;
        end else begin
            ber_cyc_q <= ber_cyc_n;
            ber_cnt_q <= ber_cnt_n;
            hi_ber_q  <= hi_ber_n;
        end
    end

    assign bus.hi_ber = hi_ber_q;
`else
    assign hi_ber_n   = 1'b0;
    assign bus.hi_ber = 1'b0;
`endif

    // Slip is a same-cycle request; a held reset suppresses it.
    assign bus.slip         = slip_c & reset;
    assign bus.block_lock   = block_lock_q;
    assign bus.descr_bypass = descr_bypass_q;
    assign bus.data_ok      = data_ok_q;

endmodule

// File: tb/tb_pcs_rx_lock_ctrl.sv
// Directed bench for pcs_rx_lock_ctrl: acquisition, slip/realign, loss of
// lock, window clearing, hdr_valid gaps, mid-lock reset and (when built with
// PCS_HI_BER_EN) the hi-BER monitor with a 100-cycle window.
module tb_pcs_rx_lock_ctrl;
    localparam logic [7:0] CLEAN = 8'h66;   // lanes 3..0 = 01,10,01,10
    localparam logic [7:0] L2BAD = 8'h76;   // lane 2 = 11
    localparam logic [7:0] L0BAD = 8'h64;   // lane 0 = 00

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic last_slip;
    int   slip_cnt;

    pcs_rx_lock_ctrl_if #(.LANES(4)) bus ();

    pcs_rx_lock_ctrl #(.BER_CYC(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Apply one cycle of input; slip is sampled mid-cycle, registered outputs
    // are valid on return (#1 after the edge).
    task automatic step(input logic v, input logic [7:0] h);
        bus.hdr_valid = v;
        bus.sync_hdr  = h;
        @(negedge clk);
        last_slip = bus.slip;
        if (bus.slip === 1'b1) slip_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic v, input logic [7:0] h);
        for (int i = 0; i < n; i++) step(v, h);
    endtask

    task automatic hold_reset();
        reset = 1'b0;
        step(1'b1, L2BAD);
        step(1'b0, CLEAN);
        reset = 1'b1;
        slip_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, L2BAD);
        n_vec++; if (last_slip !== 1'b0) begin n_err++; $display("FAIL reset_slip act=%b exp=0", last_slip); end
        step(1'b0, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b0) begin n_err++; $display("FAIL reset_block_lock act=%b exp=0", bus.block_lock); end
        n_vec++; if (bus.descr_bypass !== 1'b1) begin n_err++; $display("FAIL reset_bypass act=%b exp=1", bus.descr_bypass); end
        n_vec++; if (bus.data_ok !== 1'b0) begin n_err++; $display("FAIL reset_data_ok act=%b exp=0", bus.data_ok); end
        n_vec++; if (bus.hi_ber !== 1'b0) begin n_err++; $display("FAIL reset_hi_ber act=%b exp=0", bus.hi_ber); end
        reset = 1'b1;
    endtask

    task automatic test_clean_lock();
        hold_reset();
        run(15, 1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b0) begin n_err++; $display("FAIL clean_early_lock act=%b exp=0", bus.block_lock); end
        step(1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b1) begin n_err++; $display("FAIL clean_block_lock act=%b exp=1", bus.block_lock); end
        n_vec++; if (bus.descr_bypass !== 1'b0) begin n_err++; $display("FAIL clean_bypass act=%b exp=0", bus.descr_bypass); end
        n_vec++; if (bus.data_ok !== 1'b0) begin n_err++; $display("FAIL clean_data_ok_early act=%b exp=0", bus.data_ok); end
        step(1'b1, CLEAN);
        n_vec++; if (bus.data_ok !== 1'b1) begin n_err++; $display("FAIL clean_data_ok act=%b exp=1", bus.data_ok); end
        n_vec++; if (slip_cnt !== 0) begin n_err++; $display("FAIL clean_no_slip act=%0d exp=0", slip_cnt); end
    endtask

    task automatic test_slip_unlocked();
        hold_reset();
        run(4, 1'b1, CLEAN);
        step(1'b1, L2BAD);
        n_vec++; if (last_slip !== 1'b1) begin n_err++; $display("FAIL slip_pulse act=%b exp=1", last_slip); end
        // Invalid headers during the wait must be ignored.
        run(8, 1'b1, L0BAD);
        n_vec++; if (slip_cnt !== 1) begin n_err++; $display("FAIL slip_single act=%0d exp=1", slip_cnt); end
        run(15, 1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b0) begin n_err++; $display("FAIL slip_early_lock act=%b exp=0", bus.block_lock); end
        step(1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b1) begin n_err++; $display("FAIL slip_relock act=%b exp=1", bus.block_lock); end
    endtask

    task automatic test_inv_limit();
        hold_reset();
        run(17, 1'b1, CLEAN);
        run(64, 1'b1, L0BAD);
        n_vec++; if (slip_cnt !== 0 || bus.block_lock !== 1'b1) begin n_err++; $display("FAIL inv64_kept slips=%0d lock=%b exp slips=0 lock=1", slip_cnt, bus.block_lock); end
        n_vec++; if (bus.hi_ber !== 1'b0) begin n_err++; $display("FAIL inv64_hi_ber act=%b exp=0", bus.hi_ber); end
        step(1'b1, L0BAD);
        n_vec++; if (last_slip !== 1'b1) begin n_err++; $display("FAIL inv65_slip act=%b exp=1", last_slip); end
        n_vec++; if (bus.block_lock !== 1'b0) begin n_err++; $display("FAIL inv65_block_lock act=%b exp=0", bus.block_lock); end
        n_vec++; if (bus.descr_bypass !== 1'b1) begin n_err++; $display("FAIL inv65_bypass act=%b exp=1", bus.descr_bypass); end
        n_vec++; if (bus.data_ok !== 1'b0) begin n_err++; $display("FAIL inv65_data_ok act=%b exp=0", bus.data_ok); end
    endtask

    task automatic test_window();
        hold_reset();
        run(16, 1'b1, CLEAN);
        // Locked cycles 1..256 form window 1; cycle 256 is its boundary.
        run(64, 1'b1, L0BAD);
        run(192, 1'b1, CLEAN);
        run(64, 1'b1, L0BAD);
        n_vec++; if (slip_cnt !== 0 || bus.block_lock !== 1'b1) begin n_err++; $display("FAIL window_clear slips=%0d lock=%b exp slips=0 lock=1", slip_cnt, bus.block_lock); end
        run(191, 1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b1) begin n_err++; $display("FAIL window_pre_boundary act=%b exp=1", bus.block_lock); end
        step(1'b1, L0BAD);
        n_vec++; if (last_slip !== 1'b1) begin n_err++; $display("FAIL window_priority_slip act=%b exp=1", last_slip); end
        n_vec++; if (bus.block_lock !== 1'b0) begin n_err++; $display("FAIL window_priority_lock act=%b exp=0", bus.block_lock); end
    endtask

    task automatic test_hdr_gap_and_reset();
        hold_reset();
        run(8, 1'b1, CLEAN);
        run(10, 1'b0, L0BAD);
        n_vec++; if (slip_cnt !== 0 || bus.block_lock !== 1'b0) begin n_err++; $display("FAIL gap_hold slips=%0d lock=%b exp slips=0 lock=0", slip_cnt, bus.block_lock); end
        run(7, 1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b0) begin n_err++; $display("FAIL gap_early_lock act=%b exp=0", bus.block_lock); end
        step(1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b1) begin n_err++; $display("FAIL gap_lock act=%b exp=1", bus.block_lock); end
        step(1'b1, CLEAN);
        n_vec++; if (bus.data_ok !== 1'b1) begin n_err++; $display("FAIL gap_data_ok act=%b exp=1", bus.data_ok); end
        reset = 1'b0;
        step(1'b1, CLEAN);
        n_vec++; if (bus.block_lock !== 1'b0 || bus.descr_bypass !== 1'b1 || bus.data_ok !== 1'b0 || bus.hi_ber !== 1'b0)
            begin n_err++; $display("FAIL midlock_reset lock=%b byp=%b ok=%b hb=%b exp 0 1 0 0", bus.block_lock, bus.descr_bypass, bus.data_ok, bus.hi_ber); end
        reset = 1'b1;
        step(1'b1, L2BAD);
        n_vec++; if (last_slip !== 1'b1) begin n_err++; $display("FAIL post_reset_unlocked_slip act=%b exp=1", last_slip); end
    endtask

`ifdef PCS_HI_BER_EN
    task automatic test_hi_ber();
        hold_reset();
        run(16, 1'b1, CLEAN);
        // Locked cycles c=0.. ; BER windows end at c=99,199,299,399.
        run(200, 1'b1, CLEAN);
        run(55, 1'b1, L0BAD);
        step(1'b1, CLEAN);
        run(41, 1'b1, L0BAD);
        n_vec++; if (bus.hi_ber !== 1'b0) begin n_err++; $display("FAIL ber96_hi_ber act=%b exp=0", bus.hi_ber); end
        step(1'b1, L0BAD);
        n_vec++; if (bus.hi_ber !== 1'b1) begin n_err++; $display("FAIL ber97_hi_ber act=%b exp=1", bus.hi_ber); end
        n_vec++; if (bus.data_ok !== 1'b0 || bus.block_lock !== 1'b1) begin n_err++; $display("FAIL ber97_ok_lock ok=%b lock=%b exp 0 1", bus.data_ok, bus.block_lock); end
        run(101, 1'b1, CLEAN);
        n_vec++; if (bus.hi_ber !== 1'b1) begin n_err++; $display("FAIL ber_hold act=%b exp=1", bus.hi_ber); end
        step(1'b1, CLEAN);
        n_vec++; if (bus.hi_ber !== 1'b0 || bus.data_ok !== 1'b1) begin n_err++; $display("FAIL ber_clear hb=%b ok=%b exp 0 1", bus.hi_ber, bus.data_ok); end
    endtask
`endif

    initial begin
        reset         = 1'b0;
        bus.hdr_valid = 1'b0;
        bus.sync_hdr  = CLEAN;
        slip_cnt      = 0;
        last_slip     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_clean_lock();
        test_slip_unlocked();
        test_inv_limit();
        test_window();
        test_hdr_gap_and_reset();
`ifdef PCS_HI_BER_EN
        test_hi_ber();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
